req_encoder_8_3: RTL and testbench

- Sequential 8-to-3 request encoder. It is the inverse path of the 3-to-8 one-hot select decoder in the single-cycle datapath.
- It captures single-cycle request pulses on 8 one-hot lines into a pending register.
- It presents the winning line as a registered 3-bit index under a valid/ack handshake.
- It sits between one-hot event sources (e.g. exception/interrupt lines) and control logic that consumes a 3-bit select.

---
 rtl/req_enc_pkg.sv | 12 +
 rtl/prio_encoder_8_3.sv | 25 ++
 rtl/req_encoder_8_3.sv | 66 ++++++
 tb/tb_req_encoder_8_3.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/req_enc_pkg.sv
// req_enc_pkg: shared state encoding, width derivation and legality helpers for the request encoder.
package req_enc_pkg;
  typedef enum logic {IDLE, PRESENT} state_t;
  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction
  function automatic bit num_req_legal(input int n);
    return n == 2 || n == 4 || n == 8;
  endfunction
endpackage

// File: rtl/prio_encoder_8_3.sv
// prio_encoder_8_3: first set bit of eligible scanning upward from base with wrap-around.
module prio_encoder_8_3 #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   base,
  output logic [IDX_W-1:0]   winner,
  output logic               hit
);
  logic [IDX_W-1:0] j;
  // Scan from the far end so the candidate nearest to base is written last and wins.
  always_comb begin
    winner = '0;
    hit = 1'b0;
    j = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = base + IDX_W'(i);
      if (eligible[j]) begin
        winner = j;
        hit = 1'b1;
      end
    end
  end
endmodule

// File: rtl/req_encoder_8_3.sv
// req_encoder_8_3: captures one-hot request pulses and presents a registered index under valid/ack.
// Build option REQ_ENC_ROUND_ROBIN_EN rotates priority from the last acked index.
module req_encoder_8_3
  import req_enc_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  output logic [IDX_W-1:0]   idx,
  output logic               idx_valid,
  input  logic               idx_ack,
  output logic [NUM_REQ-1:0] pending,
  output logic               any_pending
);
  if (!num_req_legal(NUM_REQ) || IDX_W != idx_w(NUM_REQ)) begin : g_bad_cfg
    $error("req_encoder_8_3: illegal NUM_REQ/IDX_W combination");
  end
  state_t state, state_nx;
  logic [IDX_W-1:0] idx_nx, base_sel, winner;
  logic [NUM_REQ-1:0] pending_nx, clr, eligible;
  logic fire, hit;
  assign idx_valid = state == PRESENT;
  assign fire = idx_valid & idx_ack;
  assign clr = fire ? NUM_REQ'(1) << idx : '0;
  assign eligible = pending & ~mask;
  assign any_pending = |eligible;
  // A new request on the bit being acked overrides the clear.
  assign pending_nx = (pending & ~clr) | req;
`ifdef REQ_ENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] base;
  assign base_sel = fire ? idx + IDX_W'(1) : base;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) base <= '0;
    else base <= base_sel;
`else
  assign base_sel = '0;
`endif
  prio_encoder_8_3 #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_prio (
    .eligible(eligible & ~clr),
    .base    (base_sel),
    .winner  (winner),
    .hit     (hit)
  );
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    if (state == IDLE || fire) begin
      state_nx = hit ? PRESENT : IDLE;
      idx_nx = hit ? winner : idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      pending <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      pending <= pending_nx;
    end
endmodule

// File: tb/tb_req_encoder_8_3.sv
// tb_req_encoder_8_3: directed and random stimulus against a queue-based reference model with a scoreboard.
module tb_req_encoder_8_3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] mask = '0;
  logic idx_ack = 1'b0;
  logic [2:0] idx;
  logic idx_valid;
  logic [7:0] pending;
  logic any_pending;
  int n_checks = 0;
  int n_fail = 0;
  int sb[$];
  int m_pend[8] = '{default: 0};
  int m_valid = 0;
  int m_idx = 0;
  int m_base = 0;

  req_encoder_8_3 #(.NUM_REQ(8), .IDX_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mask       (mask),
    .idx        (idx),
    .idx_valid  (idx_valid),
    .idx_ack    (idx_ack),
    .pending    (pending),
    .any_pending(any_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_vec();
    int v = 0;
    for (int i = 0; i < 8; i++) v += m_pend[i] << i;
    return v;
  endfunction

  // Reference model: a set of pending lines plus the currently presented line.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pend = '{default: 0};
      m_valid = 0;
      m_idx = 0;
      m_base = 0;
      sb.delete();
    end else begin
      int cl;
      int w;
      int nxt[8];
      bit found;
      cl = (m_valid != 0 && idx_ack) ? m_idx : -1;
      for (int i = 0; i < 8; i++) nxt[i] = ((m_pend[i] != 0 && i != cl) || req[i]) ? 1 : 0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
      if (cl >= 0) m_base = (cl + 1) % 8;
`endif
      if (m_valid == 0 || cl >= 0) begin
        found = 0;
        for (int k = 0; k < 8; k++) begin
          w = (m_base + k) % 8;
          if (!found && m_pend[w] != 0 && !mask[w] && w != cl) begin
            found = 1;
            m_idx = w;
          end
        end
        m_valid = found ? 1 : 0;
        if (found) sb.push_back(m_idx);
      end
      m_pend = nxt;
    end
  end

  // Monitor: pops an expected index whenever the DUT presents a new one.
  initial begin
    bit prev_valid = 0;
    bit prev_fire = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 0;
        prev_fire = 0;
      end else begin
        check("valid", int'(idx_valid), m_valid);
        check("pending", int'(pending), model_vec());
        check("any_pending", int'(any_pending), int'((model_vec() & ~int'(mask)) != 0));
        if (idx_valid) begin
          if (!prev_valid || prev_fire) begin
            if (sb.size() == 0) check("sb_empty", int'(idx), -1);
            else check("idx_order", int'(idx), sb.pop_front());
          end else check("idx_hold", int'(idx), m_idx);
        end
        prev_valid = idx_valid;
        prev_fire = idx_valid && idx_ack;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    mask = '0;
    idx_ack = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    repeat (2) tick();
    check("rst_pending", int'(pending), 0);
    check("rst_valid", int'(idx_valid), 0);
    check("rst_idx", int'(idx), 0);
    check("rst_any", int'(any_pending), 0);
    rst_n = 1'b1;
    tick();
    req = 8'h20;
    tick();
    req = '0;
    tick();
    check("single_valid", int'(idx_valid), 1);
    check("single_idx", int'(idx), 5);
    repeat (10) begin
      tick();
      check("single_hold", int'(idx), 5);
    end
    idx_ack = 1'b1;
    tick();
    idx_ack = 1'b0;
    tick();
    do_reset();
    req = 8'h91;
    idx_ack = 1'b1;
    tick();
    req = '0;
    tick();
    check("b2b_0", int'(idx), 0);
    tick();
    check("b2b_4", int'(idx), 4);
    tick();
    check("b2b_7", int'(idx), 7);
    tick();
    check("b2b_drop", int'(idx_valid), 0);
    check("b2b_empty", int'(pending), 0);
    do_reset();
    mask = 8'h04;
    req = 8'h0C;
    tick();
    req = '0;
    tick();
    check("mask_idx", int'(idx), 3);
    idx_ack = 1'b1;
    tick();
    idx_ack = 1'b0;
    check("mask_drop", int'(idx_valid), 0);
    check("mask_pend", int'(pending), 8'h04);
    mask = '0;
    tick();
    check("unmask_idx", int'(idx), 2);
    check("unmask_valid", int'(idx_valid), 1);
    idx_ack = 1'b1;
    tick();
    idx_ack = 1'b0;
    do_reset();
    req = 8'h02;
    tick();
    req = '0;
    tick();
    check("sbc_idx", int'(idx), 1);
    req = 8'h02;
    idx_ack = 1'b1;
    tick();
    req = '0;
    idx_ack = 1'b0;
    check("sbc_pend", int'(pending), 8'h02);
    tick();
    check("sbc_repres", int'(idx), 1);
    check("sbc_valid", int'(idx_valid), 1);
    idx_ack = 1'b1;
    tick();
    idx_ack = 1'b0;
    do_reset();
    req = 8'hFF;
    idx_ack = 1'b1;
    tick();
    req = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("all8_seq", int'(idx), i);
    end
    req = 8'h81;
    tick();
    req = '0;
    tick();
    check("rr_wrap0", int'(idx), 0);
    tick();
    check("rr_wrap7", int'(idx), 7);
    idx_ack = 1'b0;
    tick();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      req = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 7) == 0) mask = 8'($urandom);
      idx_ack = 1'($urandom_range(0, 1));
      tick();
    end
    req = '0;
    mask = '0;
    idx_ack = 1'b1;
    repeat (20) tick();
    check("drain_pend", int'(pending), 0);
    idx_ack = 1'b0;
    req = 8'hA5;
    tick();
    req = '0;
    repeat (2) tick();
    check("pre_rst_pend", int'(pending), 8'hA5);
    check("pre_rst_valid", int'(idx_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pend", int'(pending), 0);
    check("async_valid", int'(idx_valid), 0);
    check("async_any", int'(any_pending), 0);
    @(posedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_valid", int'(idx_valid), 0);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
